// File: rtl/scr1_wb_host_pkg.sv
// Shared types for the Wishbone host master: FSM states and the command
// word that travels through the command FIFO.
package scr1_wb_host_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } scr1_wbh_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } scr1_wbh_cmd_s;

  localparam int CMD_W = $bits(scr1_wbh_cmd_s);

endpackage

// File: rtl/scr1_wb_cmd_fifo.sv
// Command FIFO for the Wishbone host master. Synchronous push/pop with
// full/empty flags. There is no bypass path: a push is refused while full even
// if a pop happens on the same edge, and a pop only ever returns stored data.
module scr1_wb_cmd_fifo
  import scr1_wb_host_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [CMD_W-1:0] push_data,
  input  logic             pop,
  output logic [CMD_W-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);

  logic [CMD_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array: written on an accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/scr1_wb_host_master.sv
// Wishbone classic initiator. Commands are queued in a small FIFO and issued
// as single read/write cycles, one outstanding at a time. Each transfer ends
// on err_i, ack_i or a timeout, and its result is held on the response channel
// until consumed.
//
// Handshakes: a transfer on cmd_* or rsp_* happens on a rising clk edge where
// valid and ready are both high. The offering side holds valid and payload
// stable until that edge; ready may change freely and never depends on valid.
module scr1_wb_host_master
  import scr1_wb_host_pkg::*;
#(
  parameter int CMD_FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        rsp_tmo,
  output logic        busy,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  // Counter only needs to reach TIMEOUT_CYCLES-1, so it never saturates.
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  scr1_wbh_state_e state, state_n;
  logic [TW-1:0]   tmo_cnt, tmo_n;

  scr1_wbh_cmd_s push_cmd;
  scr1_wbh_cmd_s pop_cmd;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;

  logic          load;
  logic          term;
  logic          cyc_n, stb_n, we_n;
  logic [31:0]   adr_n, dat_n;
  logic [3:0]    sel_n;
  logic          rsp_valid_n, rsp_err_n, rsp_tmo_n;
  logic [31:0]   rsp_dat_n;

  assign push_cmd  = '{we: cmd_we, adr: cmd_adr, dat: cmd_dat, sel: cmd_sel};
  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && !fifo_full;
  assign busy      = !fifo_empty || (state != IDLE);

  scr1_wb_cmd_fifo #(
    .DEPTH (CMD_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .pop_data  (pop_cmd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next-state and registered-output logic; every register holds by default.
  always_comb begin
    state_n     = state;
    tmo_n       = tmo_cnt;
    fifo_pop    = 1'b0;
    load        = 1'b0;
    term        = 1'b0;
    cyc_n       = wb_cyc_o;
    stb_n       = wb_stb_o;
    we_n        = wb_we_o;
    adr_n       = wb_adr_o;
    dat_n       = wb_dat_o;
    sel_n       = wb_sel_o;
    rsp_valid_n = rsp_valid;
    rsp_dat_n   = rsp_dat;
    rsp_err_n   = rsp_err;
    rsp_tmo_n   = rsp_tmo;

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          load = 1'b1;
        end
      end
      REQ: begin
        // err_i wins over ack_i; the timeout only fires with neither present.
        if (wb_err_i) begin
          term      = 1'b1;
          rsp_err_n = 1'b1;
          rsp_dat_n = '0;
        end else if (wb_ack_i) begin
          term      = 1'b1;
          rsp_dat_n = wb_we_o ? 32'h0 : wb_dat_i;
        end else if (tmo_cnt == TMO_LAST) begin
          term      = 1'b1;
          rsp_tmo_n = 1'b1;
          rsp_dat_n = '0;
        end else begin
          tmo_n = tmo_cnt + TMO_ONE;
        end
        if (term) begin
          cyc_n       = 1'b0;
          stb_n       = 1'b0;
          rsp_valid_n = 1'b1;
          state_n     = RSP;
        end
      end
      RSP: begin
        // stb is already low here, so a back-to-back command still gets a
        // one-cycle gap before its strobe.
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          rsp_err_n   = 1'b0;
          rsp_tmo_n   = 1'b0;
          rsp_dat_n   = '0;
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (load) begin
      fifo_pop = 1'b1;
      state_n  = REQ;
      tmo_n    = '0;
      cyc_n    = 1'b1;
      stb_n    = 1'b1;
      we_n     = pop_cmd.we;
      adr_n    = pop_cmd.adr;
      dat_n    = pop_cmd.we ? pop_cmd.dat : 32'h0;
      sel_n    = pop_cmd.sel;
    end
  end

  // State, timeout counter, Wishbone and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
      rsp_tmo   <= 1'b0;
    end else begin
      state     <= state_n;
      tmo_cnt   <= tmo_n;
      wb_cyc_o  <= cyc_n;
      wb_stb_o  <= stb_n;
      wb_we_o   <= we_n;
      wb_adr_o  <= adr_n;
      wb_dat_o  <= dat_n;
      wb_sel_o  <= sel_n;
      rsp_valid <= rsp_valid_n;
      rsp_dat   <= rsp_dat_n;
      rsp_err   <= rsp_err_n;
      rsp_tmo   <= rsp_tmo_n;
    end
  end

endmodule

// File: tb/tb_scr1_wb_host_master.sv
// Bench for scr1_wb_host_master: directed scenarios plus a randomized command
// stream, checked against a transaction-level model (memory + response queue).
`timescale 1ns/1ps
module tb_scr1_wb_host_master;

  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  localparam int M_ACK    = 0;
  localparam int M_ERR    = 1;
  localparam int M_ERRACK = 2;
  localparam int M_NONE   = 3;

  typedef struct {
    int          mode;
    int          lat;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } plan_t;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        rsp_tmo;
  logic        busy;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  scr1_wb_host_master #(
    .CMD_FIFO_DEPTH (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .rsp_tmo   (rsp_tmo),
    .busy      (busy),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_sel_o  (wb_sel_o),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_i  (wb_ack_i),
    .wb_err_i  (wb_err_i)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [33:0] exp_q[$];          // {err, tmo, dat}
  plan_t       plan_q[$];         // per-command responder behaviour, in order
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] resp_mem  [logic [31:0]];

  int accepted  = 0;
  int started   = 0;
  int resp_done = 0;
  int rr_mode   = 1;              // 0 random, 1 always ready, 2 never ready

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    logic [31:0] t;
    t = a ^ 32'h5A5A_A5A5;
    return t * 32'h9E37_79B1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] resp_read(input logic [31:0] a);
    return resp_mem.exists(a) ? resp_mem[a] : init_word(a);
  endfunction

  // Reference: what the response for a command must be, given how the
  // responder will treat it. Writes land in the model only when acked cleanly.
  function automatic logic [33:0] model_rsp(input plan_t p);
    logic [31:0] w;
    logic [33:0] r;
    w = model_read(p.adr);
    r = {2'b10, 32'h0};
    if (p.mode == M_NONE) begin
      r = {2'b01, 32'h0};
    end else if (p.mode == M_ACK) begin
      if (p.we) begin
        model_mem[p.adr] = merge(w, p.dat, p.sel);
        r = {2'b00, 32'h0};
      end else begin
        r = {2'b00, w};
      end
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int mode, input int lat);
    plan_t p;
    int    guard;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    guard = 0;
    while (!cmd_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_wait", {63'h0, cmd_ready}, 64'h1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    accepted++;
    p.mode = mode;
    p.lat  = lat;
    p.we   = we;
    p.adr  = adr;
    p.dat  = dat;
    p.sel  = sel;
    plan_q.push_back(p);
    exp_q.push_back(model_rsp(p));
    #1;
    cmd_valid = 1'b0;
    cmd_dat   = $urandom;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("idle_busy", {63'h0, busy}, 64'h0);
    check("idle_rsp_left", 64'(exp_q.size()), 64'h0);
  endtask

  // ---------------- responder + monitor ----------------
  plan_t cur;
  logic  in_xfer   = 1'b0;
  logic  term_prev = 1'b0;
  logic  prev_hs   = 1'b0;
  logic  rsp_pend  = 1'b0;
  int    stb_cnt   = 0;

  initial begin
    wb_ack_i  = 1'b0;
    wb_err_i  = 1'b0;
    wb_dat_i  = '0;
    rsp_ready = 1'b0;
    cur.mode = M_NONE; cur.lat = 0; cur.we = 1'b0;
    cur.adr = '0; cur.dat = '0; cur.sel = '0;
    forever begin
      @(negedge clk);
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = $urandom;
      if (!rst_n) begin
        in_xfer = 1'b0; term_prev = 1'b0; prev_hs = 1'b0; rsp_pend = 1'b0;
        rsp_ready = 1'b0;
      end else begin
        if (prev_hs) resp_done++;
        prev_hs = 1'b0;
        case (rr_mode)
          0:       rsp_ready = 1'($urandom_range(0, 1));
          1:       rsp_ready = 1'b1;
          default: rsp_ready = 1'b0;
        endcase

        if (wb_cyc_o && wb_stb_o) begin
          if (in_xfer) begin
            check("stb_gap", {63'h0, term_prev}, 64'h0);
            if (term_prev) in_xfer = 1'b0;
          end
          if (!in_xfer) begin
            in_xfer = 1'b1;
            stb_cnt = 0;
            started++;
            check("plan_avail", {63'h0, plan_q.size() != 0}, 64'h1);
            if (plan_q.size() != 0) cur = plan_q.pop_front();
          end
          stb_cnt++;
          check("wb_adr", {32'h0, wb_adr_o}, {32'h0, cur.adr});
          check("wb_we", {63'h0, wb_we_o}, {63'h0, cur.we});
          check("wb_sel", {60'h0, wb_sel_o}, {60'h0, cur.sel});
          check("wb_dat_o", {32'h0, wb_dat_o}, {32'h0, cur.we ? cur.dat : 32'h0});
          term_prev = 1'b0;
          if (cur.mode != M_NONE && stb_cnt == cur.lat + 1) begin
            term_prev = 1'b1;
            if (cur.mode == M_ACK) begin
              wb_ack_i = 1'b1;
              if (wb_we_o) resp_mem[wb_adr_o] = merge(resp_read(wb_adr_o), wb_dat_o, wb_sel_o);
              else         wb_dat_i = resp_read(wb_adr_o);
            end else if (cur.mode == M_ERR) begin
              wb_err_i = 1'b1;
            end else begin
              wb_err_i = 1'b1;
              wb_ack_i = 1'b1;
              wb_dat_i = resp_read(wb_adr_o);
            end
          end
        end else begin
          if (in_xfer) begin
            check("stb_len", 64'(stb_cnt), 64'(cur.mode == M_NONE ? TMO : cur.lat + 1));
            in_xfer = 1'b0;
          end
          term_prev = 1'b0;
          // Stray terminations while no strobe is up must be ignored.
          if ($urandom_range(0, 7) == 0) wb_ack_i = 1'b1;
          if ($urandom_range(0, 7) == 0) wb_err_i = 1'b1;
        end

        check("cmd_ready", {63'h0, cmd_ready}, {63'h0, (accepted - started) < DEPTH});
        check("busy", {63'h0, busy}, {63'h0, (accepted - resp_done) != 0});

        if (rsp_pend && !rsp_valid) check("rsp_dropped", {63'h0, rsp_valid}, 64'h1);
        if (rsp_valid) begin
          check("rsp_avail", {63'h0, exp_q.size() != 0}, 64'h1);
          if (exp_q.size() != 0)
            check("rsp", {30'h0, rsp_err, rsp_tmo, rsp_dat}, {30'h0, exp_q[0]});
          if (rsp_ready) begin
            prev_hs  = 1'b1;
            rsp_pend = 1'b0;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
          end else begin
            rsp_pend = 1'b1;
          end
        end else begin
          rsp_pend = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int g;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_dat   = '0;
    cmd_sel   = '0;
    rr_mode   = 1;

    // Reset state
    #22;
    check("rst_cyc", {63'h0, wb_cyc_o}, 64'h0);
    check("rst_stb", {63'h0, wb_stb_o}, 64'h0);
    check("rst_we", {63'h0, wb_we_o}, 64'h0);
    check("rst_adr", {32'h0, wb_adr_o}, 64'h0);
    check("rst_dat", {32'h0, wb_dat_o}, 64'h0);
    check("rst_sel", {60'h0, wb_sel_o}, 64'h0);
    check("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    check("rst_rsp", {30'h0, rsp_err, rsp_tmo, rsp_dat}, 64'h0);
    check("rst_cmd_ready", {63'h0, cmd_ready}, 64'h1);
    check("rst_busy", {63'h0, busy}, 64'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Write then read back, with issue latency
    send_cmd(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, M_ACK, 0);
    @(negedge clk);
    check("lat_e0_stb", {63'h0, wb_stb_o}, 64'h0);
    @(negedge clk);
    check("lat_e1_stb", {63'h0, wb_stb_o}, 64'h1);
    send_cmd(1'b0, 32'h0000_0100, 32'h0, 4'hF, M_ACK, 0);
    wait_idle();

    // Burst: first transfer is slow so the FIFO fills behind it
    send_cmd(1'b0, 32'h0000_0104, 32'h0, 4'hF, M_ACK, 6);
    for (int i = 0; i < 4; i++)
      send_cmd(1'(i), 32'h0000_0108 + 32'(4 * i), $urandom, 4'hF, M_ACK, i % 3);
    @(negedge clk);
    check("burst_full", {63'h0, cmd_ready}, 64'h0);
    send_cmd(1'b0, 32'h0000_0110, 32'h0, 4'h3, M_ACK, 1);
    wait_idle();

    // Timeout: responder never answers
    send_cmd(1'b0, 32'h0000_0120, 32'h0, 4'hF, M_NONE, 0);
    wait_idle();

    // err and ack together, then a normal command still issues
    send_cmd(1'b0, 32'h0000_0100, 32'h0, 4'hF, M_ERRACK, 1);
    send_cmd(1'b0, 32'h0000_0100, 32'h0, 4'hF, M_ACK, 0);
    wait_idle();

    // Response backpressure with a second command queued
    rr_mode = 2;
    send_cmd(1'b1, 32'h0000_0124, 32'h1234_5678, 4'h5, M_ACK, 0);
    send_cmd(1'b0, 32'h0000_0124, 32'h0, 4'hF, M_ACK, 0);
    g = 0;
    while (!rsp_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    repeat (10) begin
      @(negedge clk);
      check("bp_stb", {63'h0, wb_stb_o}, 64'h0);
      check("bp_valid", {63'h0, rsp_valid}, 64'h1);
    end
    @(posedge clk);
    #1 rr_mode = 1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("bp_restart_stb", {63'h0, wb_stb_o}, 64'h1);
    wait_idle();

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      int r;
      int m;
      if (i % 10 == 0) rr_mode = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      m = (r < 7) ? M_ACK : (r == 7) ? M_ERR : (r == 8) ? M_ERRACK : M_NONE;
      send_cmd(1'($urandom_range(0, 1)), 32'h0000_0100 + 32'($urandom_range(0, 7)) * 4,
               $urandom, 4'($urandom_range(0, 15)), m, $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rr_mode = 1;
    wait_idle();

    // Reset in the middle of a transfer, with another command queued
    send_cmd(1'b0, 32'h0000_0100, 32'h0, 4'hF, M_NONE, 0);
    send_cmd(1'b0, 32'h0000_0104, 32'h0, 4'hF, M_ACK, 0);
    g = 0;
    while (!wb_stb_o && g < 20) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_cyc", {63'h0, wb_cyc_o}, 64'h0);
    check("mid_rst_stb", {63'h0, wb_stb_o}, 64'h0);
    check("mid_rst_adr", {32'h0, wb_adr_o}, 64'h0);
    check("mid_rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    check("mid_rst_cmd_ready", {63'h0, cmd_ready}, 64'h1);
    exp_q.delete();
    plan_q.delete();
    accepted  = 0;
    started   = 0;
    resp_done = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", {63'h0, cmd_ready}, 64'h1);
    check("post_rst_busy", {63'h0, busy}, 64'h0);
    check("post_rst_stb", {63'h0, wb_stb_o}, 64'h0);
    send_cmd(1'b0, 32'h0000_0100, 32'h0, 4'hF, M_ACK, 1);
    wait_idle();

    check("plan_left", 64'(plan_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
